g3f_deadtime_driver: RTL and testbench

- Downstream consumer of the 3-flop twisted-ring phase generator.
- Takes the generator's three phase levels (Qa, Qb, Qc) and resynchronises them into the system clock domain.
- Produces complementary high-side/low-side gate enables per phase, with programmable dead time.
- Also reports step, direction and sequence faults; it is the last digital stage before the pad drivers.

---
 rtl/g3f_deadtime_driver.sv | 163 ++++++++++++++++
 tb/tb_g3f_deadtime_driver.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g3f_deadtime_driver.sv
// Gate driver for the twisted-ring phase generator: resynchronises Qa/Qb/Qc,
// checks the ring sequence and drives complementary hs/ls with a dead band.
module g3f_deadtime_driver #(
  parameter int SYNC_STAGES = 2,
  parameter int DT_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DT_W-1:0] dead_time,
  input  logic [2:0]      ph_in,
  output logic [2:0]      hs,
  output logic [2:0]      ls,
  output logic            step_pulse,
  output logic            dir,
  output logic            fault
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam int              PC_W      = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [PC_W-1:0] PRIME_CNT = PC_W'(SYNC_STAGES);

  function automatic logic is_legal(input logic [2:0] c);
    return (c != 3'b010) && (c != 3'b101);
  endfunction

  // Illegal codes map to themselves so they never look like a step.
  function automatic logic [2:0] ring_succ(input logic [2:0] c);
    case (c)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b111;
      3'b111:  return 3'b110;
      3'b110:  return 3'b100;
      3'b100:  return 3'b000;
      default: return c;
    endcase
  endfunction

  function automatic logic [2:0] ring_pred(input logic [2:0] c);
    case (c)
      3'b000:  return 3'b100;
      3'b100:  return 3'b110;
      3'b110:  return 3'b111;
      3'b111:  return 3'b011;
      3'b011:  return 3'b001;
      3'b001:  return 3'b000;
      default: return c;
    endcase
  endfunction

  function automatic logic [DT_W-1:0] sat_dec(input logic [DT_W-1:0] v);
    return (v == '0) ? '0 : v - DT_W'(1);
  endfunction

  logic [2:0]      ph_sync [SYNC_STAGES];
  logic [2:0]      ph_s;
  logic [2:0]      ph_q;
  logic [2:0]      chg;
  logic [PC_W-1:0] prime_cnt;
  logic            primed;
  logic            mv;
  logic            fwd;
  logic            rev;
  logic            bad;
  logic [1:0]      st  [3];
  logic [DT_W-1:0] cnt [3];

  // Stage: asynchronous phase levels into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) ph_sync[s] <= '0;
    end else begin
      ph_sync[0] <= ph_in;
      for (int s = 1; s < SYNC_STAGES; s++) ph_sync[s] <= ph_sync[s-1];
    end
  end

  assign ph_s = ph_sync[SYNC_STAGES-1];

  // Primed once the synchroniser has flushed the reset zeros and ph_q holds a real sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (!primed) begin
      if (prime_cnt == PRIME_CNT) primed <= 1'b1;
      else                        prime_cnt <= prime_cnt + PC_W'(1);
    end
  end

  // Stage: sequence check of ph_s against the previous code
  assign chg = ph_s ^ ph_q;
  assign mv  = primed && (ph_s != ph_q);
  assign fwd = mv && is_legal(ph_q) && (ph_s == ring_succ(ph_q));
  assign rev = mv && is_legal(ph_q) && (ph_s == ring_pred(ph_q));
  assign bad = primed && (!is_legal(ph_s) || (mv && !fwd && !rev));

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q       <= '0;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      fault      <= 1'b0;
    end else begin
      ph_q       <= ph_s;
      step_pulse <= fwd || rev;
      if (fwd)      dir <= 1'b1;
      else if (rev) dir <= 1'b0;
      fault <= en ? (fault || bad) : 1'b0;
    end
  end

  // Stage: per-phase dead-band sequencer
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || !en || fault) begin
        st[i]  <= ST_OFF;
        cnt[i] <= '0;
      end else begin
        case (st[i])
          ST_OFF: begin
            if (primed) begin
              st[i]  <= ST_DEAD;
              cnt[i] <= dead_time;
            end
          end
          ST_DEAD: begin
            if (chg[i])              cnt[i] <= dead_time;
            else if (cnt[i] == '0)   st[i]  <= ST_DRIVE;
            else                     cnt[i] <= sat_dec(cnt[i]);
          end
          ST_DRIVE: begin
            if (chg[i]) begin
              st[i]  <= ST_DEAD;
              cnt[i] <= dead_time;
            end
          end
          default: begin
            st[i]  <= ST_OFF;
            cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  // Fault and enable also mask combinationally so the pads drop without waiting for the FSM.
  always_comb begin
    hs = '0;
    ls = '0;
    for (int i = 0; i < 3; i++) begin
      if ((st[i] == ST_DRIVE) && en && !fault) begin
        hs[i] = ph_q[i];
        ls[i] = !ph_q[i];
      end
    end
  end

endmodule

// File: tb/tb_g3f_deadtime_driver.sv
// Scenario bench for g3f_deadtime_driver against a deadline-based reference model.
module tb_g3f_deadtime_driver;

  localparam int S    = 2;
  localparam int DT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [DT_W-1:0] dead_time;
  logic [2:0]      ph_in;
  logic [2:0]      hs;
  logic [2:0]      ls;
  logic            step_pulse;
  logic            dir;
  logic            fault;
  logic [8:0]      dut_vec;

  int n_chk  = 0;
  int n_fail = 0;

  g3f_deadtime_driver #(.SYNC_STAGES(S), .DT_W(DT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .dead_time(dead_time), .ph_in(ph_in),
    .hs(hs), .ls(ls), .step_pulse(step_pulse), .dir(dir), .fault(fault)
  );

  always #5 clk = ~clk;

  assign dut_vec = {hs, ls, step_pulse, dir, fault};

  // Reference model: input history plus, per phase, the edge at which drive may resume.
  logic [2:0] samp [$];
  int         r;
  logic       m_fault, m_dir, m_step;
  bit         armed [3];
  int         on_at [3];
  logic [8:0] exp_vec;

  function automatic logic [2:0] s_val(input int j);
    if (j >= 1 && j <= samp.size()) return samp[j-1];
    return 3'b000;
  endfunction

  function automatic int ring_pos(input logic [2:0] c);
    case (c)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      3'b110:  return 4;
      3'b100:  return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] ring_code(input int p);
    case (p)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b011;
      3:       return 3'b111;
      4:       return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  task automatic tick();
    logic [2:0] prev, cur, phq, e_hs, e_ls;
    bit judge, bad, fwd, rev, f_pre, drv;
    int d;
    @(posedge clk);
    if (rst) begin
      samp.delete();
      r = 0; m_fault = 0; m_dir = 0; m_step = 0;
      for (int i = 0; i < 3; i++) begin armed[i] = 0; on_at[i] = 0; end
    end else begin
      r++;
      samp.push_back(ph_in);
      judge = (r >= S + 2);
      prev  = s_val(r - S - 1);
      cur   = s_val(r - S);
      fwd = 0; rev = 0; bad = 0;
      if (judge) begin
        if (ring_pos(cur) < 0) bad = 1;
        else if (cur != prev) begin
          if (ring_pos(prev) < 0) bad = 1;
          else begin
            d   = (ring_pos(cur) - ring_pos(prev) + 6) % 6;
            fwd = (d == 1);
            rev = (d == 5);
            bad = !(fwd || rev);
          end
        end
      end
      f_pre  = m_fault;
      m_step = fwd || rev;
      if (fwd)      m_dir = 1;
      else if (rev) m_dir = 0;
      m_fault = en ? (m_fault || bad) : 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (!en || f_pre) armed[i] = 0;
        else if (!armed[i]) begin
          if (r >= S + 2) begin armed[i] = 1; on_at[i] = r + int'(dead_time) + 1; end
        end else if (judge && (cur[i] != prev[i])) on_at[i] = r + int'(dead_time) + 1;
      end
    end
    phq = s_val(r - S);
    for (int i = 0; i < 3; i++) begin
      drv     = armed[i] && (r >= on_at[i]) && en && !m_fault;
      e_hs[i] = drv && phq[i];
      e_ls[i] = drv && !phq[i];
    end
    exp_vec = {e_hs, e_ls, m_step, m_dir, m_fault};
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; dead_time = 4'd3; ph_in = 3'b000;
    repeat (3) begin
      tick();
      n_chk++;
      if (dut_vec !== 9'b0) begin
        n_fail++; $display("FAIL reset_state got=%b exp=%b", dut_vec, 9'b0);
      end
    end
  endtask

  task automatic test_prime_dead();
    int first_on = -1;
    int steps = 0;
    rst = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL prime_cycle c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
      end
      if (step_pulse) steps++;
      if (first_on < 0 && ls === 3'b111) first_on = c;
    end
    n_chk++;
    if (first_on != S + 6) begin
      n_fail++; $display("FAIL prime_first_drive got=%0d exp=%0d", first_on, S + 6);
    end
    n_chk++;
    if ({hs, ls, step_pulse, fault} !== 8'b000_111_0_0 || steps != 0) begin
      n_fail++; $display("FAIL prime_settled got=%b/%0d exp=%b/0", {hs, ls, step_pulse, fault}, steps, 8'b000_111_0_0);
    end
  endtask

  task automatic test_ring(input bit forward);
    int steps = 0, dir_bad = 0, overlap = 0, runs = 0;
    int off_run [3];
    bit was_on [3];
    bit on;
    dead_time = 4'd2;
    for (int i = 0; i < 3; i++) begin off_run[i] = 0; was_on[i] = hs[i] | ls[i]; end
    for (int k = 0; k < 6; k++) begin
      ph_in = forward ? ring_code((k + 1) % 6) : ring_code((6 - (k + 1)) % 6);
      repeat (20) begin
        tick();
        n_chk++;
        if (dut_vec !== exp_vec) begin
          n_fail++; $display("FAIL ring_cycle fwd=%0d got=%b exp=%b", forward, dut_vec, exp_vec);
        end
        if (step_pulse) begin steps++; if (dir !== forward) dir_bad++; end
        if (|(hs & ls)) overlap++;
        for (int i = 0; i < 3; i++) begin
          on = hs[i] | ls[i];
          if (!on) off_run[i]++;
          else begin
            if (!was_on[i]) begin
              runs++;
              n_chk++;
              if (off_run[i] != 3) begin
                n_fail++; $display("FAIL ring_deadband ph=%0d got=%0d exp=3", i, off_run[i]);
              end
            end
            off_run[i] = 0;
          end
          was_on[i] = on;
        end
      end
    end
    n_chk++;
    if (steps != 6 || dir_bad != 0 || runs != 6) begin
      n_fail++; $display("FAIL ring_steps fwd=%0d got steps=%0d dir_bad=%0d runs=%0d exp 6/0/6", forward, steps, dir_bad, runs);
    end
    n_chk++;
    if (overlap != 0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL ring_safe fwd=%0d got overlap=%0d fault=%b exp 0/0", forward, overlap, fault);
    end
  endtask

  task automatic test_double_jump();
    int f_at = -1, first_on = -1;
    ph_in = 3'b001;
    repeat (20) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL jump_pre got=%b exp=%b", dut_vec, exp_vec); end
    end
    ph_in = 3'b111;
    for (int c = 1; c <= S + 14; c++) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL jump_cycle c=%0d got=%b exp=%b", c, dut_vec, exp_vec); end
      if (f_at < 0 && fault === 1'b1) f_at = c;
    end
    n_chk++;
    if (f_at != S + 1) begin n_fail++; $display("FAIL jump_fault_latency got=%0d exp=%0d", f_at, S + 1); end
    n_chk++;
    if ({hs, ls, step_pulse, fault} !== 8'b000_000_0_1) begin
      n_fail++; $display("FAIL jump_off got=%b exp=%b", {hs, ls, step_pulse, fault}, 8'b000_000_0_1);
    end
    en = 0;
    tick(); n_chk++;
    if (fault !== 1'b0 || dut_vec !== exp_vec) begin
      n_fail++; $display("FAIL jump_clear got=%b exp=%b", dut_vec, exp_vec);
    end
    en = 1;
    for (int c = 1; c <= 12; c++) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL rearm_cycle c=%0d got=%b exp=%b", c, dut_vec, exp_vec); end
      if (first_on < 0 && hs === 3'b111) first_on = c;
    end
    n_chk++;
    if (first_on != 4) begin n_fail++; $display("FAIL rearm_first_drive got=%0d exp=4", first_on); end
  endtask

  task automatic test_illegal_reset();
    int first_on = -1;
    ph_in = 3'b101;
    repeat (8) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL illegal_cycle got=%b exp=%b", dut_vec, exp_vec); end
    end
    n_chk++;
    if ({hs, ls, fault} !== 7'b000_000_1) begin
      n_fail++; $display("FAIL illegal_off got=%b exp=%b", {hs, ls, fault}, 7'b000_000_1);
    end
    ph_in = 3'b100;
    repeat (S + 3) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL illegal_hold got=%b exp=%b", dut_vec, exp_vec); end
    end
    en = 0;
    tick();
    en = 1; dead_time = 4'd15;
    repeat (5) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL dead15_cycle got=%b exp=%b", dut_vec, exp_vec); end
    end
    n_chk++;
    if (dir !== 1'b1 || fault !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset got dir=%b fault=%b exp 1/0", dir, fault);
    end
    rst = 1;
    tick(); n_chk++;
    if (dut_vec !== 9'b0) begin n_fail++; $display("FAIL mid_reset got=%b exp=%b", dut_vec, 9'b0); end
    rst = 0;
    for (int c = 1; c <= S + 22; c++) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL reprime_cycle c=%0d got=%b exp=%b", c, dut_vec, exp_vec); end
      if (first_on < 0 && hs === 3'b100) first_on = c;
    end
    n_chk++;
    if (first_on != S + 18) begin n_fail++; $display("FAIL reprime_first_drive got=%0d exp=%0d", first_on, S + 18); end
  endtask

  task automatic test_dt_change();
    int first_on = -1, steps = 0;
    bit seen_off = 0;
    dead_time = 4'd2;
    ph_in = 3'b000;
    for (int c = 1; c <= S + 16; c++) begin
      tick(); n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL dtchg_cycle c=%0d got=%b exp=%b", c, dut_vec, exp_vec); end
      if (step_pulse) steps++;
      if (!hs[2] && !ls[2]) seen_off = 1;
      if (first_on < 0 && seen_off && hs[2]) first_on = c;
      if (c == 1) ph_in = 3'b100;
      if (c == S + 1) dead_time = 4'd9;
    end
    n_chk++;
    if (first_on != S + 12) begin n_fail++; $display("FAIL dtchg_first_drive got=%0d exp=%0d", first_on, S + 12); end
    n_chk++;
    if (steps != 2 || fault !== 1'b0) begin
      n_fail++; $display("FAIL dtchg_steps got steps=%0d fault=%b exp 2/0", steps, fault);
    end
  endtask

  task automatic test_random();
    int idx = 5;
    int act, hold;
    repeat (120) begin
      act = $urandom_range(0, 19);
      if (act < 15) begin
        idx = (idx + ($urandom_range(0, 1) ? 1 : 5)) % 6;
        ph_in = ring_code(idx);
      end else if (act < 17) ph_in = 3'($urandom_range(0, 7));
      else if (act < 19)     dead_time = 4'($urandom_range(0, 15));
      else                   en = 0;
      if (m_fault && $urandom_range(0, 2) == 0) en = 0;
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        tick(); n_chk++;
        if (dut_vec !== exp_vec || |(hs & ls)) begin
          n_fail++; $display("FAIL random_cycle r=%0d got=%b exp=%b", r, dut_vec, exp_vec);
        end
        if (h == 0) en = 1;
      end
    end
  endtask

  initial begin
    rst = 1; en = 0; dead_time = '0; ph_in = 3'b000;
    test_reset();
    test_prime_dead();
    test_ring(1'b1);
    test_ring(1'b0);
    test_double_jump();
    test_illegal_reset();
    test_dt_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
